// File: rtl/bus_grant_scheduler_pkg.sv
`default_nettype none
// ============================================================================
// bus_sched_pkg : shared state encoding and helpers for bus_grant_scheduler
// Rev 1.0
// ============================================================================
package bus_sched_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN  = 2'd1,
    TURN = 2'd2
  } sched_state_t;

  localparam int DEFAULT_TIMEOUT = 64;
  localparam int MAX_MASTERS     = 8;

  function automatic logic [2:0] onehot_to_idx(input logic [MAX_MASTERS-1:0] oh);
    logic [2:0] idx;
    idx = '0;
    for (int i = 0; i < MAX_MASTERS; i++) begin
      if (oh[i]) idx = 3'(i);
    end
    return idx;
  endfunction

endpackage
`default_nettype wire

// File: rtl/bus_grant_scheduler_if.sv
`default_nettype none
// ============================================================================
// bus_grant_scheduler_if : request/grant/split signal bundle of the scheduler
// Rev 1.0
// ============================================================================
interface bus_grant_scheduler_if #(
  parameter int NUM_MASTERS = 2,
  parameter int NUM_SLAVES  = 3,
  parameter int SLV_ID_W    = 2
);
  logic [NUM_MASTERS-1:0] req;
  logic                   done;
  logic                   split;
  logic [SLV_ID_W-1:0]    split_slv;
  logic [NUM_SLAVES-1:0]  slv_ready;
  logic [NUM_MASTERS-1:0] grant;
  logic                   grant_valid;
  logic                   resume;
  logic [NUM_MASTERS-1:0] split_pending;
  logic [NUM_MASTERS-1:0] timeout_err;

  modport master (
    output req, done, split, split_slv, slv_ready,
    input  grant, grant_valid, resume, split_pending, timeout_err
  );

  modport slave (
    input  req, done, split, split_slv, slv_ready,
    output grant, grant_valid, resume, split_pending, timeout_err
  );
endinterface
`default_nettype wire

// File: rtl/bus_grant_scheduler_rr_pick.sv
`default_nettype none
// ============================================================================
// rr_pick : combinational rotate-priority picker, lowest index at/after ptr wins
// Rev 1.0
// ============================================================================
module rr_pick #(
  parameter int N     = 2,
  parameter int PTR_W = 1
) (
  input  logic [N-1:0]     req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N-1:0]     gnt
);

  logic [2*N-1:0] rot_in;
  logic [2*N-1:0] rot_out;
  logic [N-1:0]   first;

  // Rotate so ptr sits at bit 0, take the lowest set bit, rotate back.
  always_comb begin
    rot_in = {req, req} >> ptr;
    first  = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (rot_in[i]) begin
        first    = '0;
        first[i] = 1'b1;
      end
    end
    rot_out = {{N{1'b0}}, first} << ptr;
    gnt     = rot_out[N-1:0] | rot_out[2*N-1:N];
  end

endmodule
`default_nettype wire

// File: rtl/bus_grant_scheduler.sv
`default_nettype none
// ============================================================================
// bus_grant_scheduler : round-robin bus ownership with split parking/resume;
// define ARB_TIMEOUT_EN to add forced release after TIMEOUT_CYCLES.  Rev 1.0
// ============================================================================
module bus_grant_scheduler
  import bus_sched_pkg::*;
#(
  parameter int NUM_MASTERS    = 2,
  parameter int NUM_SLAVES     = 3,
  parameter int SLV_ID_W       = 2,
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT
) (
  input  logic                 clk,
  input  logic                 rstn,
  bus_grant_scheduler_if.slave bus
);

  localparam int PTR_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

  sched_state_t           state_q, state_d;
  logic [NUM_MASTERS-1:0] grant_q, grant_d;
  logic [NUM_MASTERS-1:0] pending_q, pending_d;
  logic                   resume_q, resume_d;
  logic [PTR_W-1:0]       ptr_q, ptr_d;
  logic [SLV_ID_W-1:0]    slot_q [NUM_MASTERS];
  logic [SLV_ID_W-1:0]    slot_d [NUM_MASTERS];

  logic [NUM_MASTERS-1:0] resumable, fresh, pick_res, pick_fresh;
  logic [2:0]             owner_idx;
  logic [PTR_W-1:0]       ptr_after_owner;
  logic [SLV_ID_W-1:0]    split_slv_sat;
  logic                   timeout_hit;

  // A parked master becomes eligible only when its recorded slave is ready.
  always_comb begin
    resumable = '0;
    for (int m = 0; m < NUM_MASTERS; m++) begin
      for (int s = 0; s < NUM_SLAVES; s++) begin
        if (pending_q[m] && (int'(slot_q[m]) == s)) resumable[m] = bus.slv_ready[s];
      end
    end
  end

  assign fresh           = bus.req & ~pending_q;
  assign owner_idx       = onehot_to_idx(8'(grant_q));
  assign ptr_after_owner = PTR_W'((int'(owner_idx) + 1) % NUM_MASTERS);
  assign split_slv_sat   = (int'(bus.split_slv) >= NUM_SLAVES) ? SLV_ID_W'(NUM_SLAVES - 1)
                                                               : bus.split_slv;

  rr_pick #(.N(NUM_MASTERS), .PTR_W(PTR_W)) u_pick_res (
    .req (resumable),
    .ptr (ptr_q),
    .gnt (pick_res)
  );

  rr_pick #(.N(NUM_MASTERS), .PTR_W(PTR_W)) u_pick_fresh (
    .req (fresh),
    .ptr (ptr_q),
    .gnt (pick_fresh)
  );

  always_ff @(posedge clk) begin : p_state_reg
    if (!rstn) begin
      state_q   <= IDLE;
      grant_q   <= '0;
      pending_q <= '0;
      resume_q  <= 1'b0;
      ptr_q     <= '0;
      for (int m = 0; m < NUM_MASTERS; m++) slot_q[m] <= '0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      pending_q <= pending_d;
      resume_q  <= resume_d;
      ptr_q     <= ptr_d;
      for (int m = 0; m < NUM_MASTERS; m++) slot_q[m] <= slot_d[m];
    end
  end

  always_comb begin : p_next_state
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = (|(resumable | fresh)) ? OWN : IDLE;
      OWN:     state_d = (bus.done || bus.split || timeout_hit) ? TURN : OWN;
      TURN:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin : p_outputs
    grant_d   = grant_q;
    pending_d = pending_q;
    resume_d  = resume_q;
    ptr_d     = ptr_q;
    for (int m = 0; m < NUM_MASTERS; m++) slot_d[m] = slot_q[m];
    case (state_q)
      IDLE: begin
        if (|resumable) begin
          grant_d  = pick_res;
          resume_d = 1'b1;
        end else begin
          grant_d  = pick_fresh;
          resume_d = 1'b0;
        end
      end
      OWN: begin
        // done has precedence over split; a timeout releases like done.
        if (bus.done || timeout_hit) begin
          pending_d = pending_q & ~grant_q;
          grant_d   = '0;
          resume_d  = 1'b0;
          ptr_d     = ptr_after_owner;
        end else if (bus.split) begin
          pending_d = pending_q | grant_q;
          for (int m = 0; m < NUM_MASTERS; m++) begin
            if (grant_q[m]) slot_d[m] = split_slv_sat;
          end
          grant_d  = '0;
          resume_d = 1'b0;
          ptr_d    = ptr_after_owner;
        end
      end
      default: begin
        grant_d  = '0;
        resume_d = 1'b0;
      end
    endcase
  end

  always_comb begin
    bus.grant         = grant_q;
    bus.grant_valid   = |grant_q;
    bus.resume        = resume_q;
    bus.split_pending = pending_q;
  end

`ifdef ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0]       own_cnt_q;
  logic [NUM_MASTERS-1:0] terr_q;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      own_cnt_q <= '0;
      terr_q    <= '0;
    end else begin
      own_cnt_q <= (state_q == OWN) ? own_cnt_q + 1'b1 : '0;
      terr_q    <= timeout_hit ? grant_q : '0;
    end
  end

  assign timeout_hit     = (state_q == OWN) && (own_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1))
                           && !bus.done && !bus.split;
  assign bus.timeout_err = terr_q;
`else
  logic [31:0] unused_timeout_cfg;
  assign unused_timeout_cfg = 32'(TIMEOUT_CYCLES);
  assign timeout_hit        = 1'b0;
  assign bus.timeout_err    = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_bus_grant_scheduler.sv
`default_nettype none
// Directed table-driven bench for bus_grant_scheduler (2 masters, 3 slaves).
module tb_bus_grant_scheduler;

`ifdef ARB_TIMEOUT_EN
  localparam int TO = 8;
`else
  localparam int TO = 64;
`endif

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  bus_grant_scheduler_if #(.NUM_MASTERS(2), .NUM_SLAVES(3), .SLV_ID_W(2)) bus ();

  bus_grant_scheduler #(
    .NUM_MASTERS(2), .NUM_SLAVES(3), .SLV_ID_W(2), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  typedef struct packed {
    logic       rstn;
    logic [1:0] req;
    logic       done;
    logic       split;
    logic [1:0] slv;
    logic [2:0] rdy;
    logic [1:0] g;
    logic       r;
    logic [1:0] p;
  } vec_t;

  vec_t vec[$];
  int   total  = 0;
  int   passed = 0;

  task automatic add(input logic rs, input logic [1:0] rq, input logic dn, input logic sp,
                     input logic [1:0] sl, input logic [2:0] rd,
                     input logic [1:0] g, input logic r, input logic [1:0] p);
    vec.push_back('{rs, rq, dn, sp, sl, rd, g, r, p});
  endtask

  task automatic check(input string name, input int idx, input logic [31:0] got,
                       input logic [31:0] want);
    total++;
    if (got === want) passed++;
    else $display("FAIL %s[%0d]: got %0b, want %0b", name, idx, got, want);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic rs, input logic [1:0] rq, input logic dn, input logic sp,
                       input logic [1:0] sl, input logic [2:0] rd);
    rstn          = rs;
    bus.req       = rq;
    bus.done      = dn;
    bus.split     = sp;
    bus.split_slv = sl;
    bus.slv_ready = rd;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int cnt;
    // Each row: inputs held for that cycle, expected outputs visible that cycle.
    //   rstn req  dn sp slv  rdy     grant r pend
    add(1, 2'b00, 0, 0, 2'd0, 3'b000, 2'b00, 0, 2'b00); // reset state
    add(1, 2'b01, 0, 0, 2'd0, 3'b000, 2'b00, 0, 2'b00);
    add(1, 2'b01, 0, 0, 2'd0, 3'b000, 2'b01, 0, 2'b00); // grant one cycle after req
    add(1, 2'b01, 0, 0, 2'd0, 3'b000, 2'b01, 0, 2'b00);
    add(1, 2'b01, 1, 0, 2'd0, 3'b000, 2'b01, 0, 2'b00);
    add(1, 2'b00, 0, 0, 2'd0, 3'b000, 2'b00, 0, 2'b00);
    add(1, 2'b00, 0, 0, 2'd0, 3'b000, 2'b00, 0, 2'b00);
    add(1, 2'b00, 0, 0, 2'd0, 3'b000, 2'b00, 0, 2'b00);
    add(0, 2'b00, 0, 0, 2'd0, 3'b000, 2'b00, 0, 2'b00); // reset: pointer back to 0
    add(1, 2'b11, 0, 0, 2'd0, 3'b000, 2'b00, 0, 2'b00);
    add(1, 2'b11, 0, 0, 2'd0, 3'b000, 2'b01, 0, 2'b00);
    add(1, 2'b11, 1, 0, 2'd0, 3'b000, 2'b01, 0, 2'b00);
    add(1, 2'b11, 0, 0, 2'd0, 3'b000, 2'b00, 0, 2'b00);
    add(1, 2'b11, 0, 0, 2'd0, 3'b000, 2'b00, 0, 2'b00);
    add(1, 2'b11, 0, 0, 2'd0, 3'b000, 2'b10, 0, 2'b00); // round robin -> M1
    add(1, 2'b11, 1, 0, 2'd0, 3'b000, 2'b10, 0, 2'b00);
    add(1, 2'b11, 0, 0, 2'd0, 3'b000, 2'b00, 0, 2'b00);
    add(1, 2'b11, 0, 0, 2'd0, 3'b000, 2'b00, 0, 2'b00);
    add(1, 2'b11, 1, 0, 2'd0, 3'b000, 2'b01, 0, 2'b00); // back to M0
    add(1, 2'b00, 0, 0, 2'd0, 3'b000, 2'b00, 0, 2'b00);
    add(1, 2'b00, 0, 0, 2'd0, 3'b000, 2'b00, 0, 2'b00);
    add(1, 2'b01, 0, 0, 2'd0, 3'b000, 2'b00, 0, 2'b00);
    add(1, 2'b01, 0, 0, 2'd0, 3'b000, 2'b01, 0, 2'b00);
    add(1, 2'b11, 0, 1, 2'd0, 3'b000, 2'b01, 0, 2'b00); // M0 split on slave 0
    add(1, 2'b11, 0, 0, 2'd0, 3'b000, 2'b00, 0, 2'b01);
    add(1, 2'b11, 0, 0, 2'd0, 3'b000, 2'b00, 0, 2'b01);
    add(1, 2'b11, 0, 0, 2'd0, 3'b000, 2'b10, 0, 2'b01); // M1 takes the bus
    add(1, 2'b11, 0, 0, 2'd0, 3'b001, 2'b10, 0, 2'b01);
    add(1, 2'b11, 1, 0, 2'd0, 3'b001, 2'b10, 0, 2'b01);
    add(1, 2'b11, 0, 0, 2'd0, 3'b001, 2'b00, 0, 2'b01);
    add(1, 2'b11, 0, 0, 2'd0, 3'b001, 2'b00, 0, 2'b01);
    add(1, 2'b11, 0, 0, 2'd0, 3'b001, 2'b01, 1, 2'b01); // resumed despite M1 req
    add(1, 2'b11, 1, 0, 2'd0, 3'b001, 2'b01, 1, 2'b01);
    add(1, 2'b11, 0, 0, 2'd0, 3'b000, 2'b00, 0, 2'b00);
    add(1, 2'b11, 0, 0, 2'd0, 3'b000, 2'b00, 0, 2'b00);
    add(1, 2'b10, 1, 1, 2'd0, 3'b000, 2'b10, 0, 2'b00); // done+split: done wins
    add(1, 2'b00, 0, 0, 2'd0, 3'b000, 2'b00, 0, 2'b00);
    add(1, 2'b00, 0, 0, 2'd0, 3'b000, 2'b00, 0, 2'b00);
    add(1, 2'b01, 0, 0, 2'd0, 3'b000, 2'b00, 0, 2'b00);
    add(1, 2'b11, 0, 0, 2'd0, 3'b000, 2'b01, 0, 2'b00);
    add(1, 2'b11, 0, 1, 2'd3, 3'b000, 2'b01, 0, 2'b00); // slave 3 saturates to 2
    add(1, 2'b11, 0, 0, 2'd0, 3'b000, 2'b00, 0, 2'b01);
    add(1, 2'b11, 0, 0, 2'd0, 3'b001, 2'b00, 0, 2'b01);
    add(1, 2'b11, 0, 0, 2'd0, 3'b001, 2'b10, 0, 2'b01);
    add(0, 2'b11, 0, 0, 2'd0, 3'b001, 2'b10, 0, 2'b01); // reset mid-OWN
    add(1, 2'b11, 0, 0, 2'd0, 3'b000, 2'b00, 0, 2'b00);
    add(1, 2'b11, 0, 0, 2'd0, 3'b000, 2'b01, 0, 2'b00); // M0 first after reset
    add(1, 2'b11, 1, 0, 2'd0, 3'b000, 2'b01, 0, 2'b00);
    add(1, 2'b00, 0, 0, 2'd0, 3'b111, 2'b00, 0, 2'b00);
    add(1, 2'b00, 0, 0, 2'd0, 3'b111, 2'b00, 0, 2'b00); // ready with nobody parked
    add(1, 2'b01, 0, 0, 2'd0, 3'b000, 2'b00, 0, 2'b00);
    add(1, 2'b01, 0, 0, 2'd0, 3'b000, 2'b01, 0, 2'b00);
    add(1, 2'b01, 0, 1, 2'd3, 3'b000, 2'b01, 0, 2'b00);
    add(1, 2'b01, 0, 0, 2'd0, 3'b011, 2'b00, 0, 2'b01);
    add(1, 2'b01, 0, 0, 2'd0, 3'b011, 2'b00, 0, 2'b01); // parked req ignored
    add(1, 2'b01, 0, 0, 2'd0, 3'b011, 2'b00, 0, 2'b01);
    add(1, 2'b01, 0, 0, 2'd0, 3'b100, 2'b00, 0, 2'b01);
    add(1, 2'b01, 0, 0, 2'd0, 3'b100, 2'b01, 1, 2'b01);
    add(1, 2'b01, 0, 1, 2'd1, 3'b100, 2'b01, 1, 2'b01); // re-park on slave 1
    add(1, 2'b00, 0, 0, 2'd0, 3'b100, 2'b00, 0, 2'b01);
    add(1, 2'b00, 0, 0, 2'd0, 3'b100, 2'b00, 0, 2'b01);
    add(1, 2'b00, 0, 0, 2'd0, 3'b010, 2'b00, 0, 2'b01);
    add(1, 2'b00, 0, 0, 2'd0, 3'b010, 2'b01, 1, 2'b01);
    add(1, 2'b00, 1, 0, 2'd0, 3'b000, 2'b01, 1, 2'b01);
    add(1, 2'b00, 0, 0, 2'd0, 3'b000, 2'b00, 0, 2'b00);
    add(1, 2'b00, 0, 0, 2'd0, 3'b000, 2'b00, 0, 2'b00);

    drive(0, 2'b00, 0, 0, 2'd0, 3'b000);
    repeat (2) step();

    foreach (vec[i]) begin
      drive(vec[i].rstn, vec[i].req, vec[i].done, vec[i].split, vec[i].slv, vec[i].rdy);
      check("row", i,
            {24'd0, bus.grant, bus.grant_valid, bus.resume, bus.split_pending, bus.timeout_err},
            {24'd0, vec[i].g, |vec[i].g, vec[i].r, vec[i].p, 2'b00});
      step();
    end

    // Long ownership by M1 while M0 also requests (pointer is at M1 here).
    drive(1, 2'b10, 0, 0, 2'd0, 3'b000);
    step();
    drive(1, 2'b11, 0, 0, 2'd0, 3'b000);
    check("long_first_grant", 0, 32'(bus.grant), 32'b10);
`ifdef ARB_TIMEOUT_EN
    cnt = 0;
    while (bus.grant == 2'b10 && cnt < 200) begin
      cnt++;
      step();
    end
    check("timeout_own_cycles", 0, 32'(cnt), 32'(TO));
    check("timeout_err_pulse", 0, {28'd0, bus.timeout_err, bus.grant}, {28'd0, 2'b10, 2'b00});
    step();
    check("timeout_err_clear", 0, {28'd0, bus.timeout_err, bus.grant}, {28'd0, 2'b00, 2'b00});
    step();
    check("timeout_next_m0", 0, {29'd0, bus.grant, bus.resume}, {29'd0, 2'b01, 1'b0});
    bus.done = 1'b1;
    step();
`else
    cnt = 0;
    for (int c = 0; c < 80; c++) begin
      step();
      check("long_hold", c, {28'd0, bus.grant, bus.timeout_err}, {28'd0, 2'b10, 2'b00});
    end
    bus.done = 1'b1;
    step();
`endif
    drive(1, 2'b00, 0, 0, 2'd0, 3'b000);
    check("long_release", 0, {30'd0, bus.grant}, 32'd0);
    repeat (3) step();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire
